pulse_period_decoder: RTL and testbench

- Receive end of the reconfigurable pulse timer.
- Measures the clock-cycle spacing between successive rising edges of a periodic pulse train.
- Recovers the timer's adjust value (period minus fixed timer overhead) and declares lock once the value is stable.
- Used to verify or track a remote timer's programmed rate on the same pulseClk domain.

---
 rtl/pulse_period_decoder.sv | 180 ++++++++++++++++++
 tb/tb_pulse_period_decoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pulse_period_decoder
// Description : Receive end of the reconfigurable pulse timer. Measures the
//               clock spacing between rising edges of pulseIn, recovers the
//               remote timer's adjust value (period - OFFSET) and reports lock
//               once LOCK_CNT identical measurements arrive back to back.
//               Optional macro PULSE_DECODER_SYNC_EN inserts a two-flop
//               synchronizer on pulseIn (adds 2 cycles of output latency).
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_period_decoder #(
   parameter int ADJ_W    = 8,   // width of recovered adjust value
   parameter int OFFSET   = 3,   // fixed timer overhead, period = adj + OFFSET
   parameter int LOCK_CNT = 4    // identical measurements needed for lock (2..15)
) (
   input  logic             pulseClk,
   input  logic             resetN,
   input  logic             pulseIn,
   output logic [ADJ_W-1:0] adjOut,
   output logic             adjValid,
   output logic             locked,
   output logic             errOut
);

   localparam int            CW        = ADJ_W + 2;
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] P_MIN     = CW'(OFFSET);
   localparam logic [CW-1:0] P_MAX     = CW'(OFFSET + (2 ** ADJ_W) - 1);
   localparam int            MW        = 4;
   localparam logic [MW-1:0] MATCH_TOP = MW'(LOCK_CNT - 1);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_MEASURE = 1'b1
   } state_t;

   // sampled pulse seen by the edge detector
   logic pulse_s;

`ifdef PULSE_DECODER_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   // next values of the two synchronizer stages
   always_comb begin
      sync1_d = pulseIn;
      sync2_d = sync1_q;
   end

   // two-flop synchronizer, cleared on reset so no false edge appears
   always_ff @(posedge pulseClk or negedge resetN) begin
      if (!resetN) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign pulse_s = sync2_q;
`else
   assign pulse_s = pulseIn;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ADJ_W-1:0] adj_q, adj_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             locked_q, locked_d;
   logic [MW-1:0]    match_q, match_d;
   logic             have_prev_q, have_prev_d;
   logic             prev_q, prev_d;

   logic             rise;
   logic             in_range;
   logic [ADJ_W-1:0] meas;

   // a held-high level yields exactly one edge
   assign rise     = pulse_s & ~prev_q;
   assign in_range = (cnt_q >= P_MIN) && (cnt_q <= P_MAX);
   assign meas     = ADJ_W'(cnt_q - P_MIN);

   // measurement state machine, lock tracking and next output values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      adj_d       = adj_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      locked_d    = locked_q;
      match_d     = match_q;
      have_prev_d = have_prev_q;
      prev_d      = pulse_s;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            // first edge only arms the counter; no period exists yet
            if (rise) begin
               cnt_d   = CNT_ONE;
               state_d = S_MEASURE;
            end
         end

         S_MEASURE: begin
            if (rise) begin
               // counter holds clocks since the previous edge
               cnt_d = CNT_ONE;
               if (in_range) begin
                  valid_d     = 1'b1;
                  adj_d       = meas;
                  if (have_prev_q && (meas == adj_q)) begin
                     match_d = (match_q == MATCH_TOP) ? match_q : match_q + 1'b1;
                  end else begin
                     match_d = '0;
                  end
                  locked_d    = (match_d == MATCH_TOP);
                  have_prev_d = 1'b1;
               end else begin
                  err_d       = 1'b1;
                  locked_d    = 1'b0;
                  match_d     = '0;
                  have_prev_d = 1'b0;
               end
            end else if (cnt_q == CNT_MAX) begin
               // no edge for the full counter range: give up and re-arm
               err_d       = 1'b1;
               locked_d    = 1'b0;
               match_d     = '0;
               have_prev_d = 1'b0;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // state and output registers; reset discards any partial period
   always_ff @(posedge pulseClk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         adj_q       <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         locked_q    <= 1'b0;
         match_q     <= '0;
         have_prev_q <= 1'b0;
         prev_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         adj_q       <= adj_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         locked_q    <= locked_d;
         match_q     <= match_d;
         have_prev_q <= have_prev_d;
         prev_q      <= prev_d;
      end
   end

   assign adjOut   = adj_q;
   assign adjValid = valid_q;
   assign locked   = locked_q;
   assign errOut   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_period_decoder
// Description : Directed self-checking bench for pulse_period_decoder.
//               Outputs are logged once per cycle; each scenario task checks
//               the log at cycles derived from the edges it drove.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_period_decoder;

`ifdef PULSE_DECODER_SYNC_EN
   localparam int OLAT = 2;
`else
   localparam int OLAT = 0;
`endif
   localparam int LOG_N = 4096;

   logic       pulseClk = 1'b0;
   logic       resetN;
   logic       pulseIn;
   logic [7:0] adjOut;
   logic       adjValid;
   logic       locked;
   logic       errOut;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;

   logic       v_log [LOG_N];
   logic       e_log [LOG_N];
   logic       l_log [LOG_N];
   logic [7:0] a_log [LOG_N];

   pulse_period_decoder #(
      .ADJ_W   (8),
      .OFFSET  (3),
      .LOCK_CNT(4)
   ) dut (
      .pulseClk(pulseClk),
      .resetN  (resetN),
      .pulseIn (pulseIn),
      .adjOut  (adjOut),
      .adjValid(adjValid),
      .locked  (locked),
      .errOut  (errOut)
   );

   always #5 pulseClk = ~pulseClk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // one clock: drive at negedge, sample 1 time unit after posedge
   task automatic tick(input logic pin);
      @(negedge pulseClk);
      pulseIn = pin;
      @(posedge pulseClk);
      #1;
      cyc++;
      if (cyc < LOG_N) begin
         v_log[cyc] = adjValid;
         e_log[cyc] = errOut;
         l_log[cyc] = locked;
         a_log[cyc] = adjOut;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   // edge now, next edge 'gap' cycles later; pulse high for 'hi' cycles
   task automatic edge_gap(input int gap, input int hi, output int ec);
      ec = 0;
      for (int i = 0; i < gap; i++) begin
         tick(i < hi);
         if (i == 0) ec = cyc;
      end
   endtask

   task automatic apply_reset();
      resetN = 1'b0;
      idle(3);
      resetN = 1'b1;
      idle(2);
   endtask

   task automatic test_reset();
      resetN  = 1'b0;
      pulseIn = 1'b0;
      idle(3);
      if (adjOut !== 8'd0) begin $display("FAIL reset_adjOut: got %0d expected 0", adjOut); n_fail++; end
      n_checks++;
      if (adjValid !== 1'b0) begin $display("FAIL reset_adjValid: got %b expected 0", adjValid); n_fail++; end
      n_checks++;
      if (locked !== 1'b0) begin $display("FAIL reset_locked: got %b expected 0", locked); n_fail++; end
      n_checks++;
      if (errOut !== 1'b0) begin $display("FAIL reset_errOut: got %b expected 0", errOut); n_fail++; end
      n_checks++;
      resetN = 1'b1;
      idle(2);
   endtask

   task automatic test_timer_train();
      int e[6];
      apply_reset();
      for (int k = 0; k < 6; k++) edge_gap(8, 1, e[k]);
      idle(OLAT + 2);
      if (v_log[e[0]+OLAT] !== 1'b0 || e_log[e[0]+OLAT] !== 1'b0) begin
         $display("FAIL train_first_edge: adjValid=%b errOut=%b expected 0 0", v_log[e[0]+OLAT], e_log[e[0]+OLAT]); n_fail++;
      end
      n_checks++;
      for (int k = 1; k < 6; k++) begin
         if (v_log[e[k]+OLAT] !== 1'b1 || a_log[e[k]+OLAT] !== 8'd5) begin
            $display("FAIL train_valid[%0d]: adjValid=%b adjOut=%0d expected 1 5", k, v_log[e[k]+OLAT], a_log[e[k]+OLAT]); n_fail++;
         end
         n_checks++;
         if (l_log[e[k]+OLAT] !== (k >= 4)) begin
            $display("FAIL train_locked[%0d]: got %b expected %b", k, l_log[e[k]+OLAT], (k >= 4)); n_fail++;
         end
         n_checks++;
      end
      if (v_log[e[1]+OLAT+1] !== 1'b0 || v_log[e[1]+OLAT-1] !== 1'b0) begin
         $display("FAIL train_strobe_width: before=%b after=%b expected 0 0", v_log[e[1]+OLAT-1], v_log[e[1]+OLAT+1]); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_boundaries();
      int e[4];
      apply_reset();
      edge_gap(3,   1, e[0]);
      edge_gap(258, 1, e[1]);
      edge_gap(259, 1, e[2]);
      edge_gap(8,   1, e[3]);
      idle(OLAT + 2);
      if (v_log[e[1]+OLAT] !== 1'b1 || a_log[e[1]+OLAT] !== 8'd0) begin
         $display("FAIL bound_period3: adjValid=%b adjOut=%0d expected 1 0", v_log[e[1]+OLAT], a_log[e[1]+OLAT]); n_fail++;
      end
      n_checks++;
      if (v_log[e[2]+OLAT] !== 1'b1 || a_log[e[2]+OLAT] !== 8'd255) begin
         $display("FAIL bound_period258: adjValid=%b adjOut=%0d expected 1 255", v_log[e[2]+OLAT], a_log[e[2]+OLAT]); n_fail++;
      end
      n_checks++;
      if (e_log[e[3]+OLAT] !== 1'b1 || v_log[e[3]+OLAT] !== 1'b0 || a_log[e[3]+OLAT] !== 8'd255 || l_log[e[3]+OLAT] !== 1'b0) begin
         $display("FAIL bound_period259: errOut=%b adjValid=%b adjOut=%0d locked=%b expected 1 0 255 0",
                  e_log[e[3]+OLAT], v_log[e[3]+OLAT], a_log[e[3]+OLAT], l_log[e[3]+OLAT]); n_fail++;
      end
      n_checks++;
      if (e_log[e[3]+OLAT+1] !== 1'b0) begin
         $display("FAIL bound_err_width: errOut=%b expected 0", e_log[e[3]+OLAT+1]); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_relock();
      int e[9];
      apply_reset();
      for (int k = 0; k < 4; k++) edge_gap(8, 1, e[k]);
      edge_gap(10, 1, e[4]);
      for (int k = 5; k < 8; k++) edge_gap(10, 1, e[k]);
      edge_gap(8, 1, e[8]);
      idle(OLAT + 2);
      if (l_log[e[4]+OLAT] !== 1'b1) begin
         $display("FAIL relock_initial_lock: got %b expected 1", l_log[e[4]+OLAT]); n_fail++;
      end
      n_checks++;
      if (v_log[e[5]+OLAT] !== 1'b1 || a_log[e[5]+OLAT] !== 8'd7 || l_log[e[5]+OLAT] !== 1'b0) begin
         $display("FAIL relock_change: adjValid=%b adjOut=%0d locked=%b expected 1 7 0", v_log[e[5]+OLAT], a_log[e[5]+OLAT], l_log[e[5]+OLAT]); n_fail++;
      end
      n_checks++;
      if (l_log[e[7]+OLAT] !== 1'b0) begin
         $display("FAIL relock_early: locked=%b expected 0", l_log[e[7]+OLAT]); n_fail++;
      end
      n_checks++;
      if (l_log[e[8]+OLAT] !== 1'b1 || a_log[e[8]+OLAT] !== 8'd7) begin
         $display("FAIL relock_final: locked=%b adjOut=%0d expected 1 7", l_log[e[8]+OLAT], a_log[e[8]+OLAT]); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_errors();
      int e[8];
      apply_reset();
      for (int k = 0; k < 4; k++) edge_gap(8, 1, e[k]);
      edge_gap(2, 1, e[4]);
      for (int k = 5; k < 8; k++) edge_gap(8, 5, e[k]);
      idle(OLAT + 2);
      if (l_log[e[4]+OLAT] !== 1'b1) begin
         $display("FAIL err_locked_before: got %b expected 1", l_log[e[4]+OLAT]); n_fail++;
      end
      n_checks++;
      if (e_log[e[5]+OLAT] !== 1'b1 || v_log[e[5]+OLAT] !== 1'b0 || l_log[e[5]+OLAT] !== 1'b0) begin
         $display("FAIL err_short_period: errOut=%b adjValid=%b locked=%b expected 1 0 0", e_log[e[5]+OLAT], v_log[e[5]+OLAT], l_log[e[5]+OLAT]); n_fail++;
      end
      n_checks++;
      if (v_log[e[6]+OLAT] !== 1'b1 || a_log[e[6]+OLAT] !== 8'd5 || l_log[e[6]+OLAT] !== 1'b0) begin
         $display("FAIL err_held_high: adjValid=%b adjOut=%0d locked=%b expected 1 5 0", v_log[e[6]+OLAT], a_log[e[6]+OLAT], l_log[e[6]+OLAT]); n_fail++;
      end
      n_checks++;
      for (int j = 1; j < 5; j++) begin
         if (v_log[e[6]+OLAT+j] !== 1'b0 || e_log[e[6]+OLAT+j] !== 1'b0) begin
            $display("FAIL err_held_single_edge[%0d]: adjValid=%b errOut=%b expected 0 0", j, v_log[e[6]+OLAT+j], e_log[e[6]+OLAT+j]); n_fail++;
         end
         n_checks++;
      end
      if (v_log[e[7]+OLAT] !== 1'b1 || a_log[e[7]+OLAT] !== 8'd5) begin
         $display("FAIL err_held_second: adjValid=%b adjOut=%0d expected 1 5", v_log[e[7]+OLAT], a_log[e[7]+OLAT]); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_timeout();
      int e0, a, b;
      apply_reset();
      edge_gap(1, 1, e0);
      idle(1030);
      if (e_log[e0+1023+OLAT] !== 1'b1) begin
         $display("FAIL timeout_strobe: errOut=%b expected 1", e_log[e0+1023+OLAT]); n_fail++;
      end
      n_checks++;
      if (e_log[e0+1022+OLAT] !== 1'b0 || e_log[e0+1024+OLAT] !== 1'b0) begin
         $display("FAIL timeout_width: before=%b after=%b expected 0 0", e_log[e0+1022+OLAT], e_log[e0+1024+OLAT]); n_fail++;
      end
      n_checks++;
      edge_gap(8, 1, a);
      edge_gap(8, 1, b);
      idle(OLAT + 2);
      if (v_log[a+OLAT] !== 1'b0 || e_log[a+OLAT] !== 1'b0) begin
         $display("FAIL timeout_rearm: adjValid=%b errOut=%b expected 0 0", v_log[a+OLAT], e_log[a+OLAT]); n_fail++;
      end
      n_checks++;
      if (v_log[b+OLAT] !== 1'b1 || a_log[b+OLAT] !== 8'd5) begin
         $display("FAIL timeout_recover: adjValid=%b adjOut=%0d expected 1 5", v_log[b+OLAT], a_log[b+OLAT]); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_reset_mid();
      int e[5];
      int f0, f1;
      apply_reset();
      for (int k = 0; k < 5; k++) edge_gap(8, 1, e[k]);
      idle(OLAT + 1);
      if (locked !== 1'b1 || adjOut !== 8'd5) begin
         $display("FAIL rstmid_pre: locked=%b adjOut=%0d expected 1 5", locked, adjOut); n_fail++;
      end
      n_checks++;
      #2;
      resetN = 1'b0;
      #1;
      if (locked !== 1'b0 || adjOut !== 8'd0 || adjValid !== 1'b0 || errOut !== 1'b0) begin
         $display("FAIL rstmid_async: locked=%b adjOut=%0d adjValid=%b errOut=%b expected 0 0 0 0", locked, adjOut, adjValid, errOut); n_fail++;
      end
      n_checks++;
      idle(2);
      resetN = 1'b1;
      idle(2);
      edge_gap(8, 1, f0);
      edge_gap(8, 1, f1);
      idle(OLAT + 2);
      if (v_log[f0+OLAT] !== 1'b0 || e_log[f0+OLAT] !== 1'b0) begin
         $display("FAIL rstmid_first_edge: adjValid=%b errOut=%b expected 0 0", v_log[f0+OLAT], e_log[f0+OLAT]); n_fail++;
      end
      n_checks++;
      if (v_log[f1+OLAT] !== 1'b1 || a_log[f1+OLAT] !== 8'd5 || l_log[f1+OLAT] !== 1'b0) begin
         $display("FAIL rstmid_second_edge: adjValid=%b adjOut=%0d locked=%b expected 1 5 0", v_log[f1+OLAT], a_log[f1+OLAT], l_log[f1+OLAT]); n_fail++;
      end
      n_checks++;
   endtask

   initial begin
      resetN  = 1'b0;
      pulseIn = 1'b0;
      test_reset();
      test_timer_train();
      test_boundaries();
      test_relock();
      test_errors();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
